// File: rtl/mc_sequencer.sv
// ---------------------------------------------------------------------------
// mc_sequencer
//
// Multi-cycle control sequencer for the 8-bit microprocessor datapath.
// Each instruction is captured from IMEM into IR during FETCH and is then
// stepped through DECODE, EXEC and, depending on the opcode, MEM and/or WB.
// The datapath control strobes are Moore outputs of STATE and IR[7:6]. They
// are registered: each edge loads the strobe pattern of the state being
// entered. Free-run (RUN), single-step (STEP) and a sticky memory-timeout
// halt are supported.
//
// Opcodes (IR[7:6]): 00 add, 01 lw, 10 sw, 11 j
//
// Ports
//   CLK         in   1      system clock, rising edge
//   RST         in   1      synchronous reset, active-low
//   RUN         in   1      fetch continuously while high
//   STEP        in   1      one-cycle pulse, runs one instruction from IDLE
//   INSTR       in   8      IMEM output for the current PC
//   MEM_READY   in   1      data memory access complete (used in MEM only)
//   IR          out  8      latched instruction
//   PC_WE       out  1      load PC this cycle
//   PC_SRC      out  1      0 = PC+1, 1 = jump target from IR
//   REG_WE      out  1      register file write enable
//   MEM_TO_REG  out  1      writeback source select, 1 = memory read data
//   MEM_RE      out  1      data memory read strobe
//   MEM_WE      out  1      data memory write strobe
//   STATE       out  3      current sequencer state
//   INSTR_DONE  out  1      pulse in the last cycle of each instruction
//   RETIRE_CNT  out  CNT_W  instructions retired since reset (wraps)
//   ERR         out  1      sticky memory-timeout fault flag
// ---------------------------------------------------------------------------
module mc_sequencer #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RUN,
    input  logic             STEP,
    input  logic [7:0]       INSTR,
    input  logic             MEM_READY,
    output logic [7:0]       IR,
    output logic             PC_WE,
    output logic             PC_SRC,
    output logic             REG_WE,
    output logic             MEM_TO_REG,
    output logic             MEM_RE,
    output logic             MEM_WE,
    output logic [2:0]       STATE,
    output logic             INSTR_DONE,
    output logic [CNT_W-1:0] RETIRE_CNT,
    output logic             ERR
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_UNUSED = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_J   = 2'b11;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_t           state;
    state_t           nxt_state;
    logic [7:0]       nxt_ir;
    logic [7:0]       wait_cnt;
    logic [7:0]       nxt_wait;
    logic [CNT_W-1:0] nxt_retire;
    logic             nxt_err;
    logic             instr_end;
    logic             done_q;
    logic             sw_done;

    logic             nxt_pc_we;
    logic             nxt_pc_src;
    logic             nxt_reg_we;
    logic             nxt_mem_to_reg;
    logic             nxt_mem_re;
    logic             nxt_mem_we;
    logic             nxt_done;

    // Next-state logic. An instruction "ends" in EXEC for j, in MEM for sw
    // and in WB for add/lw; the end handling (retire count and the choice
    // between FETCH and IDLE) is shared below.
    always_comb begin
        nxt_state  = state;
        nxt_ir     = IR;
        nxt_wait   = wait_cnt;
        nxt_err    = ERR;
        nxt_retire = RETIRE_CNT;
        instr_end  = 1'b0;

        case (state)
            S_IDLE: begin
                if (RUN || STEP) begin
                    nxt_state = S_FETCH;
                end
            end
            S_FETCH: begin
                nxt_ir    = INSTR;
                nxt_state = S_DECODE;
            end
            S_DECODE: begin
                nxt_state = S_EXEC;
            end
            S_EXEC: begin
                case (IR[7:6])
                    OP_ADD: nxt_state = S_WB;
                    OP_LW,
                    OP_SW: begin
                        nxt_state = S_MEM;
                        nxt_wait  = 8'd0;
                    end
                    default: instr_end = 1'b1;
                endcase
            end
            S_MEM: begin
                if (MEM_READY) begin
                    if (IR[7:6] == OP_LW) begin
                        nxt_state = S_WB;
                    end else begin
                        instr_end = 1'b1;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    nxt_state = S_HALT;
                    nxt_err   = 1'b1;
                end else begin
                    nxt_wait = wait_cnt + 8'd1;
                end
            end
            S_WB: begin
                instr_end = 1'b1;
            end
            S_HALT: begin
                nxt_state = S_HALT;
            end
            default: begin
                nxt_state = S_IDLE;
            end
        endcase

        if (instr_end) begin
            nxt_retire = RETIRE_CNT + CNT_W'(1);
            nxt_state  = RUN ? S_FETCH : S_IDLE;
        end
    end

    // Strobe pattern of the state about to be entered, so that the registered
    // outputs line up with STATE in the same cycle.
    always_comb begin
        nxt_pc_we      = 1'b0;
        nxt_pc_src     = 1'b0;
        nxt_reg_we     = 1'b0;
        nxt_mem_to_reg = 1'b0;
        nxt_mem_re     = 1'b0;
        nxt_mem_we     = 1'b0;
        nxt_done       = 1'b0;

        case (nxt_state)
            S_FETCH: begin
                nxt_pc_we = 1'b1;
            end
            S_EXEC: begin
                if (nxt_ir[7:6] == OP_J) begin
                    nxt_pc_we  = 1'b1;
                    nxt_pc_src = 1'b1;
                    nxt_done   = 1'b1;
                end
            end
            S_MEM: begin
                nxt_mem_re = (nxt_ir[7:6] == OP_LW);
                nxt_mem_we = (nxt_ir[7:6] == OP_SW);
            end
            S_WB: begin
                nxt_reg_we     = 1'b1;
                nxt_mem_to_reg = (nxt_ir[7:6] == OP_LW);
                nxt_done       = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Sequencer register. Reset wins over everything, including HALT.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= S_IDLE;
            IR         <= 8'd0;
            wait_cnt   <= 8'd0;
            RETIRE_CNT <= '0;
            ERR        <= 1'b0;
            PC_WE      <= 1'b0;
            PC_SRC     <= 1'b0;
            REG_WE     <= 1'b0;
            MEM_TO_REG <= 1'b0;
            MEM_RE     <= 1'b0;
            MEM_WE     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= nxt_state;
            IR         <= nxt_ir;
            wait_cnt   <= nxt_wait;
            RETIRE_CNT <= nxt_retire;
            ERR        <= nxt_err;
            PC_WE      <= nxt_pc_we;
            PC_SRC     <= nxt_pc_src;
            REG_WE     <= nxt_reg_we;
            MEM_TO_REG <= nxt_mem_to_reg;
            MEM_RE     <= nxt_mem_re;
            MEM_WE     <= nxt_mem_we;
            done_q     <= nxt_done;
        end
    end

    // A store finishes in whichever MEM cycle sees MEM_READY, which cannot
    // be known a cycle ahead, so that one completion is decoded directly.
    assign sw_done    = (state == S_MEM) && (IR[7:6] == OP_SW) && MEM_READY;
    assign INSTR_DONE = done_q || sw_done;
    assign STATE      = state;

endmodule

// File: tb/tb_mc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mc_sequencer
//
// Self-checking bench for mc_sequencer. A cycle-level model tracks each
// instruction as "cycles since FETCH" plus opcode and memory-wait history,
// and every cycle the DUT outputs are compared against what that model says
// they must be. Directed scenarios add hand-computed literal expectations,
// then a long randomized run exercises RUN/STEP/MEM_READY/reset mixes.
// ---------------------------------------------------------------------------
module tb_mc_sequencer;

    localparam int MAXW = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       step;
    logic [7:0] instr;
    logic       ready;

    logic [7:0] ir;
    logic       pc_we;
    logic       pc_src;
    logic       reg_we;
    logic       mem_to_reg;
    logic       mem_re;
    logic       mem_we;
    logic [2:0] state;
    logic       instr_done;
    logic [7:0] retire_cnt;
    logic       err;

    always #5 clk = ~clk;

    mc_sequencer #(
        .MEM_WAIT_MAX(MAXW),
        .CNT_W       (8)
    ) dut (
        .CLK        (clk),
        .RST        (rst_n),
        .RUN        (run),
        .STEP       (step),
        .INSTR      (instr),
        .MEM_READY  (ready),
        .IR         (ir),
        .PC_WE      (pc_we),
        .PC_SRC     (pc_src),
        .REG_WE     (reg_we),
        .MEM_TO_REG (mem_to_reg),
        .MEM_RE     (mem_re),
        .MEM_WE     (mem_we),
        .STATE      (state),
        .INSTR_DONE (instr_done),
        .RETIRE_CNT (retire_cnt),
        .ERR        (err)
    );

    int total = 0;
    int bad   = 0;

    // Model: mode 0 idle, 1 busy, 2 halted. k counts cycles since FETCH.
    bit         m_valid = 1'b0;
    int         m_mode  = 0;
    int         k       = 0;
    logic [1:0] m_op    = 2'b00;
    bit         m_wb    = 1'b0;
    int         m_miss  = 0;
    logic [7:0] m_ir    = 8'd0;
    int         m_retire = 0;
    bit         m_err   = 1'b0;

    // Most recent DUT sample, used by the directed literal checks.
    logic [2:0] s_state;
    logic       s_done, s_regwe, s_memre, s_memwe, s_pcwe, s_pcsrc, s_m2r, s_err;
    logic [7:0] s_retire;

    int expSeq[4] = '{1, 2, 3, 5};

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int expState();
        if (m_mode == 0) return 0;
        if (m_mode == 2) return 7;
        if (k < 3) return k + 1;
        if (m_op == 2'b00) return 5;
        if (m_op == 2'b01 && m_wb) return 5;
        return 4;
    endfunction

    task automatic applyStimulus(input logic r, input logic ru, input logic st,
                                 input logic [7:0] ins, input logic rd);
        rst_n = r;
        run   = ru;
        step  = st;
        instr = ins;
        ready = rd;
    endtask

    task automatic checkOutput();
        int   st;
        logic e_pcwe, e_pcsrc, e_regwe, e_m2r, e_re, e_we, e_done;
        s_state  = state;
        s_done   = instr_done;
        s_regwe  = reg_we;
        s_memre  = mem_re;
        s_memwe  = mem_we;
        s_pcwe   = pc_we;
        s_pcsrc  = pc_src;
        s_m2r    = mem_to_reg;
        s_err    = err;
        s_retire = retire_cnt;
        if (!m_valid) return;
        st      = expState();
        e_pcwe  = (st == 1) || (st == 3 && m_op == 2'b11);
        e_pcsrc = (st == 3 && m_op == 2'b11);
        e_regwe = (st == 5);
        e_m2r   = (st == 5 && m_op == 2'b01);
        e_re    = (st == 4 && m_op == 2'b01);
        e_we    = (st == 4 && m_op == 2'b10);
        e_done  = (st == 3 && m_op == 2'b11) || (st == 5) ||
                  (st == 4 && m_op == 2'b10 && ready);
        cmp("state",      16'(state),      16'(st));
        cmp("ir",         16'(ir),         16'(m_ir));
        cmp("pc_we",      16'(pc_we),      16'(e_pcwe));
        cmp("pc_src",     16'(pc_src),     16'(e_pcsrc));
        cmp("reg_we",     16'(reg_we),     16'(e_regwe));
        cmp("mem_to_reg", 16'(mem_to_reg), 16'(e_m2r));
        cmp("mem_re",     16'(mem_re),     16'(e_re));
        cmp("mem_we",     16'(mem_we),     16'(e_we));
        cmp("instr_done", 16'(instr_done), 16'(e_done));
        cmp("retire_cnt", 16'(retire_cnt), 16'(m_retire));
        cmp("err",        16'(err),        16'(m_err));
    endtask

    task automatic startInstr();
        m_mode = 1;
        k      = 0;
        m_wb   = 1'b0;
        m_miss = 0;
    endtask

    task automatic finishInstr();
        m_retire = (m_retire + 1) % 256;
        if (run) startInstr();
        else m_mode = 0;
    endtask

    // Advance the model across the coming rising edge using the driven inputs.
    task automatic modelAdvance();
        int st;
        if (!rst_n) begin
            m_valid  = 1'b1;
            m_mode   = 0;
            m_ir     = 8'd0;
            m_retire = 0;
            m_err    = 1'b0;
            m_miss   = 0;
            k        = 0;
            m_wb     = 1'b0;
            return;
        end
        if (!m_valid) return;
        if (m_mode == 0) begin
            if (run || step) startInstr();
        end else if (m_mode == 1) begin
            st = expState();
            if (st == 1) begin
                m_ir = instr;
                m_op = instr[7:6];
                k    = 1;
            end else if (st == 2) begin
                k = 2;
            end else if (st == 3) begin
                if (m_op == 2'b11) finishInstr();
                else k = 3;
            end else if (st == 5) begin
                finishInstr();
            end else begin
                if (ready) begin
                    if (m_op == 2'b01) m_wb = 1'b1;
                    else finishInstr();
                end else begin
                    m_miss++;
                    if (m_miss == MAXW) begin
                        m_mode = 2;
                        m_err  = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic tick(input logic r, input logic ru, input logic st,
                        input logic [7:0] ins, input logic rd);
        applyStimulus(r, ru, st, ins, rd);
        #1;
        checkOutput();
        modelAdvance();
        @(negedge clk);
    endtask

    initial begin
        int cycles;
        int cnt_a;
        int cnt_b;
        int n;

        // Reset state
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cmp("rst_state",  16'(s_state),  16'd0);
        cmp("rst_retire", 16'(s_retire), 16'd0);
        cmp("rst_err",    16'(s_err),    16'd0);

        // add: FETCH, DECODE, EXEC, WB; RUN drops so it returns to IDLE
        tick(1'b1, 1'b1, 1'b0, 8'h05, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, 1'b0, 8'h05, 1'b0);
            cmp("add_seq_state", 16'(s_state), 16'(expSeq[i]));
            cmp("add_seq_done",  16'(s_done),  16'(i == 3));
            cmp("add_seq_regwe", 16'(s_regwe), 16'(i == 3));
        end
        tick(1'b1, 1'b0, 1'b0, 8'h05, 1'b0);
        cmp("add_retire", 16'(s_retire), 16'd1);
        cmp("add_idle",   16'(s_state),  16'd0);

        // lw with two not-ready MEM cycles: 7 cycles, MEM_RE for 3
        tick(1'b1, 1'b1, 1'b0, 8'h4E, 1'b0);
        cycles = 0; cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b0, 1'b0, 8'h4E, 1'(i >= 5));
            if (s_state == 3'd0) break;
            cycles++;
            if (s_memre) cnt_a++;
            if (s_state == 3'd5 && s_m2r) cnt_b++;
        end
        cmp("lw_cycles", 16'(cycles), 16'd7);
        cmp("lw_memre",  16'(cnt_a),  16'd3);
        cmp("lw_wb_m2r", 16'(cnt_b),  16'd1);

        // j: PC_WE in FETCH and EXEC, done in third cycle, no REG_WE
        tick(1'b1, 1'b1, 1'b0, 8'hC3, 1'b0);
        cycles = 0; cnt_a = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b0, 1'b0, 8'hC3, 1'b0);
            if (i == 0) begin
                cmp("j_fetch_pcwe",  16'(s_pcwe),  16'd1);
                cmp("j_fetch_pcsrc", 16'(s_pcsrc), 16'd0);
            end
            if (i == 2) begin
                cmp("j_exec_pcsrc", 16'(s_pcsrc), 16'd1);
                cmp("j_exec_done",  16'(s_done),  16'd1);
            end
            if (s_state == 3'd0) break;
            cycles++;
            if (s_regwe) cnt_a++;
        end
        cmp("j_cycles", 16'(cycles), 16'd3);
        cmp("j_regwe",  16'(cnt_a),  16'd0);

        // sw by STEP; a second STEP in EXEC is ignored
        tick(1'b1, 1'b0, 1'b1, 8'h9B, 1'b1);
        cycles = 0; cnt_a = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b0, 1'(i == 2), 8'h9B, 1'b1);
            if (s_state == 3'd0) break;
            cycles++;
            if (s_memwe) cnt_a++;
        end
        cmp("sw_cycles", 16'(cycles), 16'd4);
        cmp("sw_memwe",  16'(cnt_a),  16'd1);
        tick(1'b1, 1'b0, 1'b0, 8'h9B, 1'b1);
        cmp("sw_step_not_queued", 16'(s_state), 16'd0);

        // sw timeout: MEM_WE for exactly MAXW cycles, then HALT
        tick(1'b1, 1'b1, 1'b0, 8'h9B, 1'b0);
        cnt_a = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, 1'b0, 1'b0, 8'h9B, 1'b0);
            if (s_memwe) cnt_a++;
            if (s_state == 3'd7) break;
        end
        cmp("to_memwe", 16'(cnt_a),   16'd15);
        cmp("to_halt",  16'(s_state), 16'd7);
        cmp("to_err",   16'(s_err),   16'd1);
        tick(1'b1, 1'b1, 1'b1, 8'h05, 1'b1);
        cmp("halt_absorbing", 16'(s_state), 16'd7);
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cmp("to_rst_state", 16'(s_state), 16'd0);
        cmp("to_rst_err",   16'(s_err),   16'd0);

        // 256 free-running adds: retire count wraps 8'hFF -> 8'h00
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        n = 0;
        for (int i = 0; i < 1100; i++) begin
            tick(1'b1, 1'b1, 1'b0, 8'h05, 1'b0);
            if (s_done) n++;
            if (n == 255) break;
        end
        cmp("wrap_done_count", 16'(n), 16'd255);
        tick(1'b1, 1'b1, 1'b0, 8'h05, 1'b0);
        cmp("wrap_ff", 16'(s_retire), 16'h00FF);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b1, 1'b0, 8'h05, 1'b0);
            if (s_done) n++;
            if (n == 256) break;
        end
        tick(1'b1, 1'b0, 1'b0, 8'h05, 1'b0);
        cmp("wrap_00", 16'(s_retire), 16'h0000);

        // reset during lw MEM abandons the instruction
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 8'h4E, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 8'h4E, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 8'h4E, 1'b0);
        cmp("rmem_was_mem", 16'(s_state), 16'd4);
        tick(1'b1, 1'b0, 1'b0, 8'h4E, 1'b1);
        cmp("rmem_state", 16'(s_state), 16'd0);
        cmp("rmem_regwe", 16'(s_regwe), 16'd0);
        cmp("rmem_memre", 16'(s_memre), 16'd0);

        // randomized mix, model-checked every cycle
        for (int i = 0; i < 4000; i++) begin
            tick(1'($urandom_range(0, 299) != 0),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 7) == 0),
                 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 2) != 0));
        end
        // long not-ready stretches so timeouts also occur under random RUN
        for (int i = 0; i < 600; i++) begin
            tick(1'($urandom_range(0, 99) != 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0),
                 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 19) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
